mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
Memory-stage controller directly downstream of the 16-bit ALU. It consumes the ALU result, opcode and store data. For LW/SW it uses the ALU result as the data-memory address and runs a req/ack handshake with a variable-latency data memory. All other ops pass the ALU result through to writeback with one cycle of latency. It stalls the upstream stage while a memory access is outstanding and flags memories that never respond.

Parameters:
TIMEOUT, 15, maximum number of ACCESS cycles to wait for mem_ack before aborting; 0 disables the timeout.
OPW, 4, opcode width; matches the ALU_OP encoding.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  upstream has an op this cycle
ex_ready  output  1  controller can accept an op; a transfer occurs when ex_valid && ex_ready
ex_op  input  OPW  ALU_OP of the op; 4'b0101 = LW, 4'b0110 = SW, all others non-memory
ex_result  input  16  ALU result; for LW/SW this is the byte address
ex_store_data  input  16  SW write data
ex_dst  input  4  destination register
ex_wen  input  1  op writes a register (used for non-memory ops only)
mem_req  output  1  memory request, held until acknowledged or aborted
mem_wr  output  1  1 = write (SW), 0 = read (LW); valid while mem_req
mem_addr  output  16  memory address; bit 0 is always 0
mem_wdata  output  16  write data
mem_ack  input  1  memory completes the request this cycle
mem_rdata  input  16  read data; valid with mem_ack on reads
wb_valid  output  1  one-cycle pulse: op retired to writeback
wb_we  output  1  register write enable for the retired op
wb_dst  output  4  destination register of the retired op
wb_data  output  16  writeback data
err_timeout  output  1  sticky; set when a memory access is aborted

Behaviour:
- States: IDLE, ACCESS. ex_ready = (state == IDLE), combinational from the state register.
- Reset (asynchronous, rst_n low): state = IDLE, mem_req = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0, wb_valid = 0, wb_we = 0, wb_dst = 0, wb_data = 0, err_timeout = 0, timeout counter = 0. Reset during ACCESS aborts the access with no writeback.
- IDLE, accept of a non-memory op: next edge sets wb_valid = 1, wb_we = ex_wen, wb_dst = ex_dst, wb_data = ex_result. Latency is 1 cycle. Back-to-back ops are accepted every cycle.
- IDLE, accept of LW/SW: next edge sets state = ACCESS, mem_req = 1, mem_wr = (op == SW), mem_addr = {ex_result[15:1], 1'b0}, mem_wdata = ex_store_data; dst is latched and the counter is cleared.
- IDLE with no accept: wb_valid = 0 next cycle; the other wb_* outputs hold their values.
- ACCESS: mem_req, mem_addr, mem_wr and mem_wdata are stable. The counter increments each cycle mem_ack is low.
- mem_ack high in ACCESS, sampled at an edge: next cycle state = IDLE, mem_req = 0, wb_valid = 1, wb_dst = latched dst.
  - LW: wb_we = 1, wb_data = mem_rdata.
  - SW: wb_we = 0, wb_data = latched address.
- Minimum accept-to-wb_valid latency for memory ops is 2 cycles (ack in the first ACCESS cycle).
- Timeout (TIMEOUT != 0): if the counter reaches TIMEOUT with mem_ack still low, next cycle state = IDLE, mem_req = 0, err_timeout = 1, wb_valid = 1, wb_we = 0.
- mem_ack arriving in the same cycle as the timeout threshold: ack wins and the access completes normally.
- mem_ack while in IDLE is ignored.
- err_timeout clears only on reset.
- wb_valid is never high on two consecutive cycles for the same op. A new op can be accepted in the same cycle a memory op's wb_valid is high, because the state is already IDLE.
- Counter width is clog2(TIMEOUT+1), minimum 1 bit.

Decomposition:
- Shared package: OP_LW = 4'b0101, OP_SW = 4'b0110, ADDR_W = 16, DATA_W = 16, state encoding (IDLE = 1'b0, ACCESS = 1'b1).
- One sub-module: mem_timeout_ctr (parameter TIMEOUT; inputs clear, enable; output expired). It is the natural split.

Test Plan:
- Reset then no ops: after rst_n rises, ex_ready = 1, mem_req = 0, wb_valid = 0, err_timeout = 0.
- Non-memory back-to-back: ADD (0x1001) result 0x1234 to r3, then XOR (0x100B) result 0x00FF to r4 on the next cycle -> wb_valid high 2 consecutive cycles with (r3, 0x1234, we = 1) then (r4, 0x00FF, we = 1); ex_ready stays 1.
- LW with 3-cycle latency: ex_result = 0x0043, r5 -> mem_req = 1, mem_addr = 0x0042, mem_wr = 0, ex_ready = 0 for 3 cycles; mem_ack with rdata 0xBEEF -> wb_valid pulse, wb_we = 1, wb_dst = 5, wb_data = 0xBEEF, then ex_ready = 1.
- SW with ack in the first ACCESS cycle: addr 0x0100, data 0xCAFE -> mem_wr = 1, mem_wdata = 0xCAFE; wb_valid with wb_we = 0 exactly 2 cycles after accept.
- Timeout (TIMEOUT = 4): LW with mem_ack never asserted -> mem_req high exactly 4 cycles then drops; err_timeout = 1 and stays 1; a following ADD retires normally. Repeat with mem_ack on the 4th cycle -> normal completion, err_timeout stays 0.
- Reset mid-access: pull rst_n low during ACCESS -> mem_req falls immediately, no wb_valid; after release, a new LW proceeds normally.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the memory-stage controller.
package mem_stage_ctrl_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_LW = 4'b0101;
    localparam logic [OP_W-1:0] OP_SW = 4'b0110;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Command presented to the data memory while a request is outstanding.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Writeback payload handed to the register file stage.
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wb_pkt_t;

    // Memory is halfword addressed: the byte-select bit is forced low.
    function automatic logic [ADDR_W-1:0] align_half(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts ACCESS cycles without an ack; flags the cycle in which the wait budget runs out.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt_q;

    // Saturating wait counter, cleared at the start of every access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Expires on the ack-less cycle that would bring the count to TIMEOUT.
    assign expired = (TIMEOUT != 0) && enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: passes ALU results to writeback, runs LW/SW memory handshakes.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned OPW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [OPW-1:0]    ex_op,
    input  logic [ADDR_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_dst,
    input  logic              ex_wen,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_dst,
    output logic [DATA_W-1:0] wb_data,
    output logic              err_timeout
);

    state_e           state_q, state_d;
    mem_cmd_t         cmd_q, cmd_d;
    logic             req_q, req_d;
    logic [REG_W-1:0] dst_q, dst_d;
    wb_pkt_t          wb_q, wb_d;
    logic             err_q, err_d;

    logic ctr_clear;
    logic ctr_en;
    logic ctr_expired;
    logic op_is_sw;
    logic op_is_mem;

    assign op_is_sw  = (ex_op == OPW'(OP_SW));
    assign op_is_mem = op_is_sw || (ex_op == OPW'(OP_LW));

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (ctr_expired)
    );

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            req_q   <= 1'b0;
            dst_q   <= '0;
            wb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            req_q   <= req_d;
            dst_q   <= dst_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-output logic; wb_valid is a single-cycle pulse.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        req_d     = req_q;
        dst_d     = dst_q;
        wb_d      = wb_q;
        wb_d.valid = 1'b0;
        err_d     = err_q;
        ctr_clear = 1'b0;
        ctr_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (op_is_mem) begin
                        state_d     = ACCESS;
                        req_d       = 1'b1;
                        cmd_d.wr    = op_is_sw;
                        cmd_d.addr  = align_half(ex_result);
                        cmd_d.wdata = ex_store_data;
                        dst_d       = ex_dst;
                        ctr_clear   = 1'b1;
                    end else begin
                        wb_d.valid = 1'b1;
                        wb_d.we    = ex_wen;
                        wb_d.dst   = ex_dst;
                        wb_d.data  = ex_result;
                    end
                end
            end
            ACCESS: begin
                ctr_en = !mem_ack;
                if (mem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_d.valid = 1'b1;
                    wb_d.we    = !cmd_q.wr;
                    wb_d.dst   = dst_q;
                    wb_d.data  = cmd_q.wr ? cmd_q.addr : mem_rdata;
                end else if (ctr_expired) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    err_d      = 1'b1;
                    wb_d.valid = 1'b1;
                    wb_d.we    = 1'b0;
                    wb_d.dst   = dst_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ex_ready    = (state_q == IDLE);
    assign mem_req     = req_q;
    assign mem_wr      = cmd_q.wr;
    assign mem_addr    = cmd_q.addr;
    assign mem_wdata   = cmd_q.wdata;
    assign wb_valid    = wb_q.valid;
    assign wb_we       = wb_q.we;
    assign wb_dst      = wb_q.dst;
    assign wb_data     = wb_q.data;
    assign err_timeout = err_q;

endmodule
